// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, 1-cycle synchronous imem interface, 2-entry
// instruction queue feeding decode over a valid/ready handshake.
module fetch_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      out_op_code
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t            state;
  logic [1:0]      count;
  logic [XLEN-1:0] pc;
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] q_pc    [2];
  logic [31:0]     q_instr [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      credit;
  logic [XLEN-1:0] redirect_target;

  assign count           = state;
  assign pop             = out_valid & out_ready;
  assign credit          = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue           = !reset && !redirect_valid && (credit < 3'd2);
  assign push            = vld_p1 & !redirect_valid;
  assign redirect_target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

  assign imem_req  = issue;
  assign imem_addr = pc;

  // Stage p0 -> p1: issue and PC advance; a redirect kills the response in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_target;
      vld_p1 <= 1'b0;
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) pc <= pc + {{(XLEN-3){1'b0}}, 3'd4};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)
        state <= (state == EMPTY) ? ONE : FULL;
      else if (pop && !push)
        state <= (state == FULL) ? ONE : EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= pc;
  end

  // Stage p1 -> queue: capture the returned word with the PC it was fetched from
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= pc_p1;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

  // Head presentation: zeroed when empty so opcode 0 reaches the decoder
  assign out_valid   = (state != EMPTY) && !reset;
  assign out_pc      = out_valid ? q_pc[rd_ptr]    : '0;
  assign out_instr   = out_valid ? q_instr[rd_ptr] : '0;
  assign out_op_code = out_instr[6:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && state == FULL));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected fetch stream queued at stimulus
// time, compared at each decode handshake; imem modelled as mem[a] = a + 0x100.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_op_code;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb_pc    [$];
  logic [31:0] sb_instr [$];
  logic [63:0] exp_req  [$];

  fetch_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_op_code    (out_op_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h3000) return 32'h00B5_0533;
    return a[31:0] + 32'h100;
  endfunction

  always @(posedge clk)
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      sb_pc.push_back(base + 64'(4 * i));
      sb_instr.push_back(mem_word(base + 64'(4 * i)));
    end
  endtask

  task automatic push_req(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) exp_req.push_back(base + 64'(4 * i));
  endtask

  task automatic sb_clear();
    sb_pc.delete();
    sb_instr.delete();
    exp_req.delete();
  endtask

  // Sample at the falling edge; pops happen for the handshake at the next rise
  task automatic neg();
    logic [63:0] epc;
    logic [31:0] ein;
    @(negedge clk);
    if (out_valid !== 1'b1) begin
      check("idle_pc", out_pc, 64'h0);
      check("idle_instr", 64'(out_instr), 64'h0);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      epc = 64'hFFFF_FFFF_FFFF_FFFF;
      ein = 32'hFFFF_FFFF;
      if (sb_pc.size() > 0) begin
        epc = sb_pc.pop_front();
        ein = sb_instr.pop_front();
      end
      check("out_pc", out_pc, epc);
      check("out_instr", 64'(out_instr), 64'(ein));
      check("out_op_code", 64'(out_op_code), 64'(ein[6:0]));
    end
    if (imem_req === 1'b1 && exp_req.size() > 0)
      check("imem_addr", imem_addr, exp_req.pop_front());
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    neg();
    pos();
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (sb_pc.size() > 0 && n < max) begin
      tick();
      n++;
    end
    check(tag, 64'(sb_pc.size()), 64'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb_clear();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    out_ready = 1'b0;
    pos();
    tick();
    neg();
    check("rst_req", 64'(imem_req), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_pc", out_pc, 64'h0);
    check("rst_instr", 64'(out_instr), 64'h0);
    check("rst_op_code", 64'(out_op_code), 64'h0);
    pos();

    // Streaming with decode always ready
    reset = 1'b0;
    out_ready = 1'b1;
    push_exp(64'h0, 8);
    push_req(64'h0, 8);
    neg();
    check("first_req", 64'(imem_req), 64'h1);
    check("lat_a_valid", 64'(out_valid), 64'h0);
    pos();
    neg();
    check("lat_b_valid", 64'(out_valid), 64'h0);
    pos();
    neg();
    check("lat_c_valid", 64'(out_valid), 64'h1);
    check("lat_c_pc", out_pc, 64'h0);
    pos();
    drain("stream_drain", 20);
    out_ready = 1'b0;

    // Backpressure for 5 cycles after the first valid
    do_reset();
    push_exp(64'h0, 4);
    push_req(64'h0, 2);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      neg();
      check("bp_valid", 64'(out_valid), 64'h1);
      check("bp_pc", out_pc, 64'h0);
      check("bp_req", 64'(imem_req), 64'h0);
      pos();
    end
    out_ready = 1'b1;
    push_req(64'h8, 2);
    for (int i = 0; i < 4; i++) begin
      neg();
      check("bp_no_gap", 64'(out_valid), 64'h1);
      pos();
    end
    check("bp_sb_empty", 64'(sb_pc.size()), 64'h0);
    out_ready = 1'b0;

    // Redirect while the request for 0x8 is in flight
    do_reset();
    out_ready = 1'b1;
    push_exp(64'h0, 2);
    push_req(64'h0, 3);
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h2003;
    neg();
    check("rd_req_blocked", 64'(imem_req), 64'h0);
    pos();
    redirect_valid = 1'b0;
    push_exp(64'h2000, 3);
    push_req(64'h2000, 3);
    neg();
    check("rd_kill_valid", 64'(out_valid), 64'h0);
    check("rd_req", 64'(imem_req), 64'h1);
    check("rd_addr", imem_addr, 64'h2000);
    pos();
    neg();
    check("rd_gap_valid", 64'(out_valid), 64'h0);
    pos();
    neg();
    check("rd_first_pc", out_pc, 64'h2000);
    pos();
    drain("rd_drain", 10);
    out_ready = 1'b0;

    // Redirect coinciding with a pop of head 0x4, 0x8 queued behind it
    do_reset();
    push_exp(64'h0, 2);
    push_req(64'h0, 3);
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    neg();
    check("cp_head", out_pc, 64'h4);
    pos();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    neg();
    check("cp_full_head", out_pc, 64'h4);
    check("cp_req_blocked", 64'(imem_req), 64'h0);
    pos();
    redirect_valid = 1'b0;
    push_exp(64'h3000, 3);
    push_req(64'h3000, 2);
    neg();
    check("cp_flush_valid", 64'(out_valid), 64'h0);
    check("cp_addr", imem_addr, 64'h3000);
    pos();
    tick();
    neg();
    check("cp_target_pc", out_pc, 64'h3000);
    check("cp_rtype_op", 64'(out_op_code), 64'h33);
    pos();
    drain("cp_drain", 10);
    out_ready = 1'b0;

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    push_exp(64'hFFFF_FFFF_FFFF_FFFC, 4);
    push_req(64'hFFFF_FFFF_FFFF_FFFC, 3);
    drain("wrap_drain", 12);
    out_ready = 1'b0;

    // Reset with the queue full
    for (int i = 0; i < 4; i++) tick();
    neg();
    check("full_valid", 64'(out_valid), 64'h1);
    check("full_req", 64'(imem_req), 64'h0);
    pos();
    reset = 1'b1;
    out_ready = 1'b1;
    sb_clear();
    neg();
    check("mr_valid", 64'(out_valid), 64'h0);
    check("mr_req", 64'(imem_req), 64'h0);
    pos();
    reset = 1'b0;
    push_exp(64'h0, 3);
    push_req(64'h0, 3);
    neg();
    check("mr_after_valid", 64'(out_valid), 64'h0);
    check("mr_after_req", 64'(imem_req), 64'h1);
    check("mr_after_addr", imem_addr, 64'h0);
    pos();
    drain("mr_drain", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
